flexbyte_stp_ctrl: RTL and testbench

Controller that sequences a `flexbyte_stp_sr` serial-to-parallel multibyte shift register. It accepts NUM_BYTES_IN-byte chunks over a valid/ready handshake and drives the register's shift_enable. When a full NUM_BYTES_OUT-byte word has been assembled, or on an explicit flush, it presents the word downstream under a second valid/ready handshake. It sits between a byte-stream producer (e.g. a receiver front end) and word-wide consumers.

---
 rtl/flexbyte_pkg.sv | 25 ++
 rtl/flexbyte_stp_sr.sv | 46 ++++
 rtl/flexbyte_stp_ctrl.sv | 124 ++++++++++++
 tb/tb_flexbyte_stp_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/flexbyte_pkg.sv
// Shared types and helpers for the flexbyte serial-to-parallel controller.
package flexbyte_pkg;

    // Controller states: no chunks held, partial word, word presented downstream.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } stp_ctrl_state_t;

    // Byte-lane mask: returns 1 when byte lane 'lane' carries valid data
    // for a word holding 'count' valid bytes out of 'nbytes'.
    // With msb set, chunks enter at the low end and migrate upward, so the
    // valid bytes of a partial word sit in the low lanes. Otherwise chunks
    // enter at the top and the valid bytes occupy the high lanes.
    function automatic logic lane_keep(input int lane, input int count,
                                       input int nbytes, input bit msb);
        if (msb) begin
            return (lane < count);
        end else begin
            return (lane >= (nbytes - count));
        end
    endfunction

endpackage

// File: rtl/flexbyte_stp_sr.sv
// Serial-to-parallel multibyte shift register. Each enabled cycle one
// NUM_BYTES_IN-byte chunk is shifted in; MSB selects the shift direction so
// the first chunk of a word ends up in the most (1) or least (0)
// significant bytes once the word is complete.
module flexbyte_stp_sr #(
    parameter int MSB           = 1,
    parameter int NUM_BYTES_IN  = 1,
    parameter int NUM_BYTES_OUT = 4
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       shift_enable,
    input  logic [NUM_BYTES_IN*8-1:0]  data_in,
    output logic [NUM_BYTES_OUT*8-1:0] data_out
);

    localparam int IW = NUM_BYTES_IN * 8;
    localparam int OW = NUM_BYTES_OUT * 8;

    logic [OW-1:0] sr_q;
    logic [OW-1:0] sr_d;

    // Next register contents: shift one chunk in from the selected end.
    always_comb begin
        sr_d = sr_q;
        if (shift_enable) begin
            if (MSB != 0) begin
                sr_d = {sr_q[OW-IW-1:0], data_in};
            end else begin
                sr_d = {data_in, sr_q[OW-1:IW]};
            end
        end
    end

    // Register storage; reset zeroes the contents.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign data_out = sr_q;

endmodule

// File: rtl/flexbyte_stp_ctrl.sv
// Sequencer for a flexbyte_stp_sr: accepts input chunks under valid/ready,
// assembles them into a word and presents the word (full or flushed
// partial) downstream under a second valid/ready handshake.
module flexbyte_stp_ctrl
    import flexbyte_pkg::*;
#(
    parameter int MSB           = 1,
    parameter int NUM_BYTES_IN  = 1,
    parameter int NUM_BYTES_OUT = 4
) (
    input  logic                               clk,
    input  logic                               n_rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NUM_BYTES_IN*8-1:0]          in_data,
    input  logic                               flush,
    output logic                               word_valid,
    input  logic                               word_ready,
    output logic [NUM_BYTES_OUT*8-1:0]         word_data,
    output logic [$clog2(NUM_BYTES_OUT+1)-1:0] word_count
);

    localparam int CHUNKS = NUM_BYTES_OUT / NUM_BYTES_IN;
    localparam int CW     = $clog2(NUM_BYTES_OUT + 1);
    localparam int CNTW   = $clog2(CHUNKS + 1);

    localparam logic [CNTW-1:0] CHUNKS_C  = CNTW'(CHUNKS);
    localparam logic [CW-1:0]   IN_BYTES  = CW'(NUM_BYTES_IN);
    localparam logic [CW-1:0]   OUT_BYTES = CW'(NUM_BYTES_OUT);

    // Reject configurations that cannot tile a word with whole chunks.
    if ((NUM_BYTES_OUT <= NUM_BYTES_IN) || ((NUM_BYTES_OUT % NUM_BYTES_IN) != 0)) begin : g_bad_cfg
        $fatal(1, "flexbyte_stp_ctrl: NUM_BYTES_OUT must be a larger multiple of NUM_BYTES_IN");
    end

    stp_ctrl_state_t           state_q;
    logic [CNTW-1:0]           count_q;
    logic [CW-1:0]             word_count_q;
    logic                      word_valid_q;

    logic                      accept;
    logic [CNTW-1:0]           count_inc;
    logic [NUM_BYTES_OUT*8-1:0] sr_data;

    // Ready depends on state only, so there is no path from in_valid.
    assign in_ready  = (state_q != FULL);
    assign accept    = in_valid & in_ready;
    assign count_inc = count_q + CNTW'(1);

    flexbyte_stp_sr #(
        .MSB           (MSB),
        .NUM_BYTES_IN  (NUM_BYTES_IN),
        .NUM_BYTES_OUT (NUM_BYTES_OUT)
    ) u_sr (
        .clk          (clk),
        .n_rst        (n_rst),
        .shift_enable (accept),
        .data_in      (in_data),
        .data_out     (sr_data)
    );

    // Controller FSM with registered word_valid/word_count. An accept that
    // coincides with a flush is taken first, so the flushed count includes it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            word_count_q <= '0;
            word_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        count_q <= count_inc;
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    if (accept) begin
                        count_q <= count_inc;
                        if (count_inc == CHUNKS_C) begin
                            word_count_q <= OUT_BYTES;
                            word_valid_q <= 1'b1;
                            state_q      <= FULL;
                        end else if (flush) begin
                            word_count_q <= CW'(count_inc) * IN_BYTES;
                            word_valid_q <= 1'b1;
                            state_q      <= FULL;
                        end
                    end else if (flush) begin
                        word_count_q <= CW'(count_q) * IN_BYTES;
                        word_valid_q <= 1'b1;
                        state_q      <= FULL;
                    end
                end
                FULL: begin
                    if (word_ready) begin
                        count_q      <= '0;
                        word_count_q <= '0;
                        word_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    count_q      <= '0;
                    word_count_q <= '0;
                    word_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign word_valid = word_valid_q;
    assign word_count = word_count_q;

    // Lane masking: stale bytes left in the register from earlier words are
    // forced to zero; with word_count cleared outside FULL the word is zero.
    for (genvar gi = 0; gi < NUM_BYTES_OUT; gi++) begin : g_lane
        assign word_data[gi*8 +: 8] =
            lane_keep(gi, int'(word_count_q), NUM_BYTES_OUT, MSB != 0) ? sr_data[gi*8 +: 8] : 8'h00;
    end

endmodule

// File: tb/tb_flexbyte_stp_ctrl.sv
// Directed testbench for flexbyte_stp_ctrl across three configurations:
// A (IN=1, OUT=4, MSB=1), B (IN=1, OUT=4, MSB=0), C (IN=2, OUT=4, MSB=1).
module tb_flexbyte_stp_ctrl;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Instance A signals
    logic        a_in_valid, a_in_ready, a_flush, a_word_valid, a_word_ready;
    logic [7:0]  a_in_data;
    logic [31:0] a_word_data;
    logic [2:0]  a_word_count;
    // Instance B signals
    logic        b_in_valid, b_in_ready, b_flush, b_word_valid, b_word_ready;
    logic [7:0]  b_in_data;
    logic [31:0] b_word_data;
    logic [2:0]  b_word_count;
    // Instance C signals
    logic        c_in_valid, c_in_ready, c_flush, c_word_valid, c_word_ready;
    logic [15:0] c_in_data;
    logic [31:0] c_word_data;
    logic [2:0]  c_word_count;

    flexbyte_stp_ctrl #(.MSB(1), .NUM_BYTES_IN(1), .NUM_BYTES_OUT(4)) u_dut_a (
        .clk(clk), .n_rst(n_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .flush(a_flush), .word_valid(a_word_valid),
        .word_ready(a_word_ready), .word_data(a_word_data), .word_count(a_word_count)
    );

    flexbyte_stp_ctrl #(.MSB(0), .NUM_BYTES_IN(1), .NUM_BYTES_OUT(4)) u_dut_b (
        .clk(clk), .n_rst(n_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .flush(b_flush), .word_valid(b_word_valid),
        .word_ready(b_word_ready), .word_data(b_word_data), .word_count(b_word_count)
    );

    flexbyte_stp_ctrl #(.MSB(1), .NUM_BYTES_IN(2), .NUM_BYTES_OUT(4)) u_dut_c (
        .clk(clk), .n_rst(n_rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .flush(c_flush), .word_valid(c_word_valid),
        .word_ready(c_word_ready), .word_data(c_word_data), .word_count(c_word_count)
    );

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_in_valid = 0; a_in_data = 0; a_flush = 0; a_word_ready = 1;
        b_in_valid = 0; b_in_data = 0; b_flush = 0; b_word_ready = 1;
        c_in_valid = 0; c_in_data = 0; c_flush = 0; c_word_ready = 1;
        #2;
        checks++; if (a_word_valid !== 1'b0) begin errors++; $display("FAIL reset_word_valid got %b exp 0", a_word_valid); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", a_in_ready); end
        checks++; if (a_word_count !== 3'd0) begin errors++; $display("FAIL reset_word_count got %0d exp 0", a_word_count); end
        checks++; if (a_word_data !== 32'h0) begin errors++; $display("FAIL reset_word_data got %h exp 00000000", a_word_data); end
        #10 n_rst = 1'b1;
        step();
        checks++; if (a_in_ready !== 1'b1 || a_word_valid !== 1'b0) begin errors++; $display("FAIL reset_release got rdy=%b vld=%b exp rdy=1 vld=0", a_in_ready, a_word_valid); end
        $display("reset: checked reset state");
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [4];
        bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'hCC; bytes[3] = 8'hDD;
        a_word_ready = 1;
        a_in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            a_in_data = bytes[i];
            step();
        end
        a_in_valid = 0;
        checks++; if (a_word_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", a_word_valid); end
        checks++; if (a_word_data !== 32'hAABBCCDD) begin errors++; $display("FAIL b2b_data got %h exp aabbccdd", a_word_data); end
        checks++; if (a_word_count !== 3'd4) begin errors++; $display("FAIL b2b_count got %0d exp 4", a_word_count); end
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %b exp 0", a_in_ready); end
        step();
        checks++; if (a_in_ready !== 1'b1 || a_word_valid !== 1'b0) begin errors++; $display("FAIL b2b_after_handoff got rdy=%b vld=%b exp rdy=1 vld=0", a_in_ready, a_word_valid); end
        $display("back_to_back: word %h count %0d", 32'hAABBCCDD, 4);
    endtask

    task automatic test_backpressure();
        logic [7:0] bytes [4];
        bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'hCC; bytes[3] = 8'hDD;
        a_word_ready = 0;
        a_in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            a_in_data = bytes[i];
            step();
        end
        a_in_data = 8'h55;
        for (int c = 0; c < 3; c++) begin
            checks++; if (a_word_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_c%0d got %b exp 1", c, a_word_valid); end
            checks++; if (a_word_data !== 32'hAABBCCDD) begin errors++; $display("FAIL bp_data_c%0d got %h exp aabbccdd", c, a_word_data); end
            checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_c%0d got %b exp 0", c, a_in_ready); end
            if (c < 2) step();
        end
        a_word_ready = 1;
        step();
        checks++; if (a_in_ready !== 1'b1 || a_word_valid !== 1'b0) begin errors++; $display("FAIL bp_handoff got rdy=%b vld=%b exp rdy=1 vld=0", a_in_ready, a_word_valid); end
        // 0x55 is still presented and should now be taken as the first chunk.
        bytes[0] = 8'h55; bytes[1] = 8'h66; bytes[2] = 8'h77; bytes[3] = 8'h88;
        for (int i = 0; i < 4; i++) begin
            a_in_data = bytes[i];
            step();
        end
        a_in_valid = 0;
        checks++; if (a_word_valid !== 1'b1 || a_word_data !== 32'h55667788) begin errors++; $display("FAIL bp_next_word got vld=%b data=%h exp vld=1 data=55667788", a_word_valid, a_word_data); end
        step();
        $display("backpressure: held %h for 3 cycles, next word %h", 32'hAABBCCDD, 32'h55667788);
    endtask

    task automatic test_flush();
        a_word_ready = 1;
        a_in_valid = 1;
        a_in_data = 8'h11; step();
        a_in_data = 8'h22; step();
        a_in_valid = 0;
        checks++; if (a_word_valid !== 1'b0) begin errors++; $display("FAIL flush_prefill_valid got %b exp 0", a_word_valid); end
        a_flush = 1; step(); a_flush = 0;
        checks++; if (a_word_valid !== 1'b1) begin errors++; $display("FAIL flush_valid got %b exp 1", a_word_valid); end
        checks++; if (a_word_count !== 3'd2) begin errors++; $display("FAIL flush_count got %0d exp 2", a_word_count); end
        checks++; if (a_word_data !== 32'h00001122) begin errors++; $display("FAIL flush_data got %h exp 00001122", a_word_data); end
        step();
        a_flush = 1;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++; if (a_word_valid !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle_c%0d got vld=%b rdy=%b exp vld=0 rdy=1", c, a_word_valid, a_in_ready); end
        end
        a_flush = 0;
        $display("flush: partial word %h count %0d, idle flush ignored", 32'h00001122, 2);
    endtask

    task automatic test_msb0();
        logic [7:0] bytes [4];
        bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03; bytes[3] = 8'h04;
        b_in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            b_in_data = bytes[i];
            step();
        end
        b_in_valid = 0;
        checks++; if (b_word_valid !== 1'b1 || b_word_data !== 32'h04030201 || b_word_count !== 3'd4) begin errors++; $display("FAIL msb0_full got vld=%b data=%h cnt=%0d exp vld=1 data=04030201 cnt=4", b_word_valid, b_word_data, b_word_count); end
        step();
        b_in_valid = 1;
        b_in_data = 8'h01; step();
        b_in_data = 8'h02; b_flush = 1; step();
        b_in_valid = 0; b_flush = 0;
        checks++; if (b_word_valid !== 1'b1) begin errors++; $display("FAIL msb0_flush_valid got %b exp 1", b_word_valid); end
        checks++; if (b_word_count !== 3'd2) begin errors++; $display("FAIL msb0_flush_count got %0d exp 2", b_word_count); end
        checks++; if (b_word_data !== 32'h02010000) begin errors++; $display("FAIL msb0_flush_data got %h exp 02010000", b_word_data); end
        step();
        $display("msb0: full %h, flushed %h", 32'h04030201, 32'h02010000);
    endtask

    task automatic test_reset_mid();
        logic [7:0] bytes [4];
        bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'hCC; bytes[3] = 8'hDD;
        a_word_ready = 1;
        a_in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            a_in_data = bytes[i];
            step();
        end
        a_in_valid = 0;
        #3 n_rst = 1'b0;
        #1;
        checks++; if (a_word_valid !== 1'b0 || a_in_ready !== 1'b1 || a_word_data !== 32'h0 || a_word_count !== 3'd0) begin errors++; $display("FAIL rstmid_async got vld=%b rdy=%b data=%h cnt=%0d exp 0/1/0/0", a_word_valid, a_in_ready, a_word_data, a_word_count); end
        step();
        step();
        checks++; if (a_word_valid !== 1'b0) begin errors++; $display("FAIL rstmid_hold got %b exp 0", a_word_valid); end
        #3 n_rst = 1'b1;
        step();
        checks++; if (a_in_ready !== 1'b1 || a_word_valid !== 1'b0) begin errors++; $display("FAIL rstmid_release got rdy=%b vld=%b exp rdy=1 vld=0", a_in_ready, a_word_valid); end
        a_in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            a_in_data = bytes[i];
            step();
        end
        a_in_valid = 0;
        checks++; if (a_word_valid !== 1'b1 || a_word_data !== 32'hAABBCCDD || a_word_count !== 3'd4) begin errors++; $display("FAIL rstmid_fresh got vld=%b data=%h cnt=%0d exp vld=1 data=aabbccdd cnt=4", a_word_valid, a_word_data, a_word_count); end
        step();
        $display("reset_mid: partial discarded, fresh word %h", 32'hAABBCCDD);
    endtask

    task automatic test_wide();
        c_in_valid = 1;
        c_in_data = 16'h1234; step();
        checks++; if (c_word_valid !== 1'b0) begin errors++; $display("FAIL wide_early_valid got %b exp 0", c_word_valid); end
        c_in_data = 16'h5678; step();
        c_in_valid = 0;
        checks++; if (c_word_valid !== 1'b1 || c_word_data !== 32'h12345678 || c_word_count !== 3'd4) begin errors++; $display("FAIL wide_full got vld=%b data=%h cnt=%0d exp vld=1 data=12345678 cnt=4", c_word_valid, c_word_data, c_word_count); end
        step();
        c_in_valid = 1;
        c_in_data = 16'h1234; step();
        c_in_valid = 0;
        c_flush = 1; step(); c_flush = 0;
        checks++; if (c_word_valid !== 1'b1 || c_word_count !== 3'd2) begin errors++; $display("FAIL wide_flush_count got vld=%b cnt=%0d exp vld=1 cnt=2", c_word_valid, c_word_count); end
        checks++; if (c_word_data !== 32'h00001234) begin errors++; $display("FAIL wide_flush_data got %h exp 00001234", c_word_data); end
        step();
        $display("wide: full %h, flushed %h", 32'h12345678, 32'h00001234);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_msb0();
        test_reset_mid();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL watchdog timeout reached at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
